// File: rtl/cache_ctrl_fsm.sv
// Write-back cache control FSM: hit/miss classification, dirty-line eviction, paced line refill.
// Optional performance counters are built when CACHE_PERF_CNT_EN is defined.
module cache_ctrl_fsm #(
  parameter int OFFSET_W = 5,
  parameter int STRB_GAP = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic                wr_rd_cpu,
  input  logic                hit,
  input  logic                line_valid,
  input  logic                line_dirty,
  output logic                busy,
  output logic                rdy,
  output logic                wen_sram,
  output logic                mux_sel,
  output logic                demux_sel,
  output logic                addr_sel,
  output logic                wr_rd_sdram,
  output logic                memstrb,
  output logic [OFFSET_W-1:0] addr_offset,
  output logic                set_valid,
  output logic                set_dirty,
  output logic                clr_dirty,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt,
  output logic [CNT_W-1:0]    evict_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR_HIT = 3'd1;
  localparam logic [2:0] S_RD_HIT = 3'd2;
  localparam logic [2:0] S_EVICT  = 3'd3;
  localparam logic [2:0] S_FILL   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [3:0] GAP_MAX = 4'(STRB_GAP);

  logic [2:0]          state_q, state_d;
  logic                wr_q, wr_d;
  logic [3:0]          gap_q, gap_d;
  logic [OFFSET_W-1:0] off_q, off_d;

  logic in_xfer, beat_end, phase_end, strb;

  assign in_xfer   = (state_q == S_EVICT) || (state_q == S_FILL);
  assign beat_end  = (gap_q == GAP_MAX);
  assign phase_end = beat_end && (off_q == '1);
  assign strb      = in_xfer && (gap_q == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      gap_q   <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      gap_q   <= gap_d;
      off_q   <= off_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    gap_d   = '0;
    off_d   = '0;
    // Beat engine: the offset wraps to 0 exactly at the end of the last beat.
    if (in_xfer) begin
      if (beat_end) begin
        off_d = off_q + OFFSET_W'(1);
      end else begin
        gap_d = gap_q + 4'd1;
        off_d = off_q;
      end
    end
    case (state_q)
      S_IDLE: begin
        if (cs) begin
          wr_d = wr_rd_cpu;
          if (hit)                          state_d = wr_rd_cpu ? S_WR_HIT : S_RD_HIT;
          else if (line_valid && line_dirty) state_d = S_EVICT;
          else                              state_d = S_FILL;
        end
      end
      S_WR_HIT, S_RD_HIT: state_d = S_DONE;
      S_EVICT:  if (phase_end) state_d = S_FILL;
      S_FILL:   if (phase_end) state_d = wr_q ? S_WR_HIT : S_RD_HIT;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    rdy         = 1'b0;
    wen_sram    = 1'b0;
    mux_sel     = 1'b0;
    demux_sel   = 1'b0;
    addr_sel    = 1'b0;
    wr_rd_sdram = 1'b0;
    memstrb     = 1'b0;
    addr_offset = '0;
    set_valid   = 1'b0;
    set_dirty   = 1'b0;
    clr_dirty   = 1'b0;
    case (state_q)
      S_WR_HIT: begin
        busy      = 1'b1;
        wen_sram  = 1'b1;
        set_dirty = 1'b1;
      end
      S_RD_HIT: begin
        busy      = 1'b1;
        demux_sel = 1'b1;
      end
      S_EVICT: begin
        busy        = 1'b1;
        addr_sel    = 1'b1;
        wr_rd_sdram = 1'b1;
        memstrb     = strb;
        addr_offset = off_q;
        clr_dirty   = phase_end;
      end
      S_FILL: begin
        // SDRAM read data is valid in the strobe cycle, so write SRAM then.
        busy        = 1'b1;
        mux_sel     = 1'b1;
        memstrb     = strb;
        wen_sram    = strb;
        addr_offset = off_q;
        set_valid   = phase_end;
      end
      S_DONE: begin
        busy = 1'b1;
        rdy  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

`ifdef CACHE_PERF_CNT_EN
  logic             acc;
  logic [CNT_W-1:0] hit_q, miss_q, evict_q;

  assign acc = (state_q == S_IDLE) && cs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q   <= '0;
      miss_q  <= '0;
      evict_q <= '0;
    end else if (acc) begin
      if (hit) begin
        if (hit_q != '1) hit_q <= hit_q + CNT_W'(1);
      end else begin
        if (miss_q != '1) miss_q <= miss_q + CNT_W'(1);
        if (line_valid && line_dirty && evict_q != '1) evict_q <= evict_q + CNT_W'(1);
      end
    end
  end

  assign hit_cnt   = hit_q;
  assign miss_cnt  = miss_q;
  assign evict_cnt = evict_q;
`else
  assign hit_cnt   = '0;
  assign miss_cnt  = '0;
  assign evict_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Scoreboard bench for cache_ctrl_fsm: stimulus pushes expected transaction timing, a monitor checks it.
module tb_cache_ctrl_fsm;
  localparam int OW = 2;
  localparam int SG = 3;
  localparam int CW = 2;
  localparam int NW = 1 << OW;
  localparam int P  = NW * (1 + SG);

  logic clk = 1'b0, rst_n = 1'b0;
  logic cs = 1'b0, wr_rd_cpu = 1'b0, hit = 1'b0, line_valid = 1'b0, line_dirty = 1'b0;
  logic busy, rdy, wen_sram, mux_sel, demux_sel, addr_sel, wr_rd_sdram, memstrb;
  logic set_valid, set_dirty, clr_dirty;
  logic [OW-1:0] addr_offset;
  logic [2:0]    state;
  logic [CW-1:0] hit_cnt, miss_cnt, evict_cnt;

  cache_ctrl_fsm #(.OFFSET_W(OW), .STRB_GAP(SG), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr_rd_cpu(wr_rd_cpu), .hit(hit),
    .line_valid(line_valid), .line_dirty(line_dirty), .busy(busy), .rdy(rdy),
    .wen_sram(wen_sram), .mux_sel(mux_sel), .demux_sel(demux_sel), .addr_sel(addr_sel),
    .wr_rd_sdram(wr_rd_sdram), .memstrb(memstrb), .addr_offset(addr_offset),
    .set_valid(set_valid), .set_dirty(set_dirty), .clr_dirty(clr_dirty), .state(state),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .evict_cnt(evict_cnt)
  );

  always #5 clk = ~clk;

  int pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  typedef struct {
    int acc; int lat; int nstrb; int clr_at; int sv_at; bit wr; bit ev;
  } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0, stray = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: accumulates per-transaction events and compares at each rdy.
  initial begin : mon
    int ns, lastc, clrc, svc;
    bit pw, psd, pdm, inev;
    exp_t e;
    ns = 0; lastc = -1; clrc = -1; svc = -1; pw = 0; psd = 0; pdm = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        ns = 0; lastc = -1; clrc = -1; svc = -1; pw = 0; psd = 0; pdm = 0;
      end else begin
        if ((memstrb || clr_dirty || set_valid || rdy) && sb.size() == 0) begin
          stray++;
          chk("stray_pulse", 1, 0);
        end else if (sb.size() != 0) begin
          e = sb[0];
          if (memstrb) begin
            if (lastc >= 0) chk("strb_spacing", pcnt - lastc, 1 + SG);
            chk("addr_offset", addr_offset, ns % NW);
            inev = e.ev && (ns < NW);
            chk("addr_sel", addr_sel, inev);
            chk("wr_rd_sdram", wr_rd_sdram, inev);
            chk("fill_wen", wen_sram, !inev);
            chk("fill_mux", mux_sel, !inev);
            lastc = pcnt;
            ns++;
          end
          if (clr_dirty) clrc = pcnt - e.acc;
          if (set_valid) svc = pcnt - e.acc;
          if (rdy) begin
            chk("latency", pcnt - e.acc, e.lat);
            chk("strb_count", ns, e.nstrb);
            chk("clr_dirty_at", clrc, e.clr_at);
            chk("set_valid_at", svc, e.sv_at);
            chk("hit_wen", pw, e.wr);
            chk("hit_set_dirty", psd, e.wr);
            chk("hit_demux", pdm, !e.wr);
            chk("rdy_busy", busy, 1);
            void'(sb.pop_front());
            ns = 0; lastc = -1; clrc = -1; svc = -1;
          end
        end
        pw  = wen_sram && !mux_sel;
        psd = set_dirty;
        pdm = demux_sel;
      end
    end
  end

  function automatic exp_t mk(input int acc, input bit w, input bit h, input bit v, input bit d);
    exp_t e;
    e.acc = acc; e.wr = w; e.ev = !h && v && d;
    if (h)         begin e.lat = 2;         e.nstrb = 0;      e.clr_at = -1; e.sv_at = -1;    end
    else if (e.ev) begin e.lat = 2 * P + 2; e.nstrb = 2 * NW; e.clr_at = P;  e.sv_at = 2 * P; end
    else           begin e.lat = P + 2;     e.nstrb = NW;     e.clr_at = -1; e.sv_at = P;     end
    return e;
  endfunction

  task automatic issue(input bit w, input bit h, input bit v, input bit d, input bit pester);
    int n;
    @(negedge clk);
    cs = 1'b1; wr_rd_cpu = w; hit = h; line_valid = v; line_dirty = d;
    sb.push_back(mk(pcnt, w, h, v, d));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (pester) begin
        // Keep cs high through DONE so its sampling edge sees a request.
        cs = rdy ? 1'b1 : ~cs;
        hit = 1'b1; line_valid = 1'b1; line_dirty = 1'b1; wr_rd_cpu = ~w;
      end else begin
        cs = 1'b0;
      end
    end while (!rdy && n < 300);
    if (!rdy) chk("rdy_timeout", 0, 1);
    @(negedge clk);
    cs = 1'b0;
    chk("idle_state", state, 0);
    chk("idle_busy_rdy", {busy, rdy}, 0);
  endtask

  task automatic chk_cnt(input string nm, input int h, input int m, input int e);
`ifdef CACHE_PERF_CNT_EN
    chk({nm, "_hit"}, hit_cnt, h);
    chk({nm, "_miss"}, miss_cnt, m);
    chk({nm, "_evict"}, evict_cnt, e);
`else
    chk({nm, "_hit"}, hit_cnt, 0);
    chk({nm, "_miss"}, miss_cnt, 0);
    chk({nm, "_evict"}, evict_cnt, 0);
`endif
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_flags"}, {busy, rdy, wen_sram, mux_sel, demux_sel, addr_sel, wr_rd_sdram,
                         memstrb, set_valid, set_dirty, clr_dirty}, 0);
    chk({nm, "_state"}, state, 0);
    chk({nm, "_offset"}, addr_offset, 0);
    chk({nm, "_cnts"}, {hit_cnt, miss_cnt, evict_cnt}, 0);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    issue(0, 1, 1, 0, 0);  // read hit
    issue(1, 1, 1, 1, 0);  // write hit, dirty bits irrelevant
    issue(1, 0, 1, 0, 0);  // clean write miss
    issue(0, 0, 0, 1, 0);  // invalid line miss goes straight to fill
    issue(0, 0, 1, 1, 1);  // dirty read miss with cs pestering during fill and done
    chk_cnt("cnt_mid", 2, 3, 1);

    // Dirty miss aborted by reset during beat 2 of the eviction.
    @(negedge clk);
    cs = 1'b1; wr_rd_cpu = 1'b0; hit = 1'b0; line_valid = 1'b1; line_dirty = 1'b1;
    e = mk(pcnt, 0, 0, 1, 1);
    sb.push_back(e);
    @(negedge clk);
    cs = 1'b0;
    repeat (2 * (1 + SG)) @(negedge clk);
    chk("beat2_strobe", {memstrb, addr_sel}, 2'b11);
    chk("beat2_offset", addr_offset, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * P) @(negedge clk);
    chk("post_abort_state", state, 0);
    chk("post_abort_stray", stray, 0);
    chk_cnt("cnt_reset", 0, 0, 0);

    for (int i = 0; i < 5; i++) issue(i[0], 1, 1, 0, 0);
    issue(1, 0, 1, 1, 0);  // dirty write miss
    chk_cnt("cnt_sat", 3, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
